// File: rtl/seven_seg_scan_if.sv
// Display bus between board value registers (master) and the scan driver (slave).
interface seven_seg_scan_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_mask;
  logic [NUM_DIGITS-1:0]   enable;
  logic [6:0]              segments;
  logic                    dp_n;
  logic                    frame_sync;

  modport master (output value, dp, load, digit_mask,
                  input  enable, segments, dp_n, frame_sync);
  modport slave  (input  value, dp, load, digit_mask,
                  output enable, segments, dp_n, frame_sync);
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex driver for an N-digit common-anode 7-segment display.
// Optional leading-zero blanking: define SEVEN_SEG_SCAN_LZB_EN.
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  seven_seg_scan_if.slave  bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int KW = $clog2(NUM_DIGITS);
  typedef logic [NUM_DIGITS-1:0][3:0] nib_t;

  logic [PW-1:0]         p_q, p_d;
  logic [KW-1:0]         k_q, k_d;
  nib_t                  shadow_q, shadow_d, active_q, active_d, value_nib;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic                  pending_q, pending_d, wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] enable_q, enable_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d, fs_q, fs_d;
  logic                  tick, boundary, show;
  logic [NUM_DIGITS-1:0] lzb;

  assign value_nib = bus.value;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

`ifdef SEVEN_SEG_SCAN_LZB_EN
  // Running AND from the top digit down; a set dp breaks the zero run.
  always_comb begin
    logic run;
    lzb = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 1; i--) begin
      run    = run & (active_q[i] == 4'h0) & ~active_dp_q[i];
      lzb[i] = run;
    end
  end
`else
  assign lzb = '0;
`endif

  always_comb begin
    tick     = (p_q == PW'(REFRESH_DIV-1));
    boundary = tick && (k_q == KW'(NUM_DIGITS-1));
    p_d      = tick ? '0 : p_q + PW'(1);
    k_d      = k_q;
    if (tick) k_d = boundary ? '0 : k_q + KW'(1);

    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    pending_d   = pending_q;
    if (bus.load) begin
      shadow_d    = value_nib;
      shadow_dp_d = bus.dp;
      // A load on the boundary bypasses the shadow so it shows this frame.
      if (boundary) begin
        active_d    = value_nib;
        active_dp_d = bus.dp;
        pending_d   = 1'b0;
      end else begin
        pending_d   = 1'b1;
      end
    end else if (boundary && pending_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
      pending_d   = 1'b0;
    end

    wrap_d   = boundary;
    show     = (p_q >= PW'(BLANK_CYCLES)) && !bus.digit_mask[k_q] && !lzb[k_q];
    enable_d = '1;
    seg_d    = 7'h7F;
    dp_n_d   = 1'b1;
    if (show) begin
      enable_d[k_q] = 1'b0;
      seg_d         = decode(active_q[k_q]);
      dp_n_d        = ~active_dp_q[k_q];
    end
    fs_d = wrap_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      k_q         <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
      pending_q   <= 1'b0;
      wrap_q      <= 1'b0;
      enable_q    <= '1;
      seg_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      p_q         <= p_d;
      k_q         <= k_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      pending_q   <= pending_d;
      wrap_q      <= wrap_d;
      enable_q    <= enable_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      fs_q        <= fs_d;
    end
  end

  assign bus.enable     = enable_q;
  assign bus.segments   = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_sync = fs_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised bench for seven_seg_scan against a time-indexed display model.
module tb_seven_seg_scan;
  localparam int N = 4, R = 4, B = 1;
  localparam int FRAME = N*R;
  localparam logic [N+8:0] RST_OBS = {{N{1'b1}}, 7'h7F, 2'b10};

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_if #(.NUM_DIGITS(N)) bus();
  seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [N+8:0] obs, want;
  assign obs = {bus.enable, bus.segments, bus.dp_n, bus.frame_sync};

  int vectors = 0, miscompares = 0;

  // Model: slot position follows directly from cycles since reset release.
  int                  m_t;
  logic [N-1:0][3:0]   m_act, m_sh;
  logic [N-1:0]        m_adp, m_sdp;
  bit                  m_pend;

  task automatic model_reset();
    m_t = 0; m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 0;
  endtask

  // Computes the output expected after the next edge, advances model and clock.
  task automatic step();
    int p, k;
    bit lz, show, bnd;
    logic [N-1:0] en;
    p = m_t % R;
    k = (m_t / R) % N;
    bnd = (m_t % FRAME) == FRAME-1;
    lz = 0;
`ifdef SEVEN_SEG_SCAN_LZB_EN
    if (k >= 1) begin
      lz = 1;
      for (int j = k; j < N; j++) if (m_act[j] != 4'h0 || m_adp[j]) lz = 0;
    end
`endif
    show = (p >= B) && !bus.digit_mask[k] && !lz;
    en = '1;
    if (show) en[k] = 1'b0;
    want = {en, show ? DEC[m_act[k]] : 7'h7F, show ? ~m_adp[k] : 1'b1,
            (m_t > 0 && m_t % FRAME == 0)};
    if (bus.load) begin
      if (bnd) begin m_act = bus.value; m_adp = bus.dp; m_pend = 0; end
      else begin m_sh = bus.value; m_sdp = bus.dp; m_pend = 1; end
    end else if (bnd && m_pend) begin
      m_act = m_sh; m_adp = m_sdp; m_pend = 0;
    end
    @(posedge clk); #1;
    m_t++;
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d);
    bus.value = v; bus.dp = d; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    if (obs !== RST_OBS) begin miscompares++; $display("FAIL reset_hold obs=%h want=%h", obs, RST_OBS); end
    vectors++;
    rst = 1'b0; model_reset();
    do_load(16'h9C3F, 4'b1010);
    for (int i = 0; i < 23; i++) begin
      step();
      if (obs !== want) begin miscompares++; $display("FAIL prescan t=%0d obs=%h want=%h", m_t, obs, want); end
      vectors++;
    end
    #2 rst = 1'b1;
    #1;
    if (obs !== RST_OBS) begin miscompares++; $display("FAIL reset_async obs=%h want=%h", obs, RST_OBS); end
    vectors++;
    @(posedge clk); #1;
    if (obs !== RST_OBS) begin miscompares++; $display("FAIL reset_held obs=%h want=%h", obs, RST_OBS); end
    vectors++;
    rst = 1'b0; model_reset();
  endtask

  task automatic test_first_slot_and_scan();
    logic [N-1:0] ee [N] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0]   es [N] = '{7'h19, 7'h30, 7'h24, 7'h79};
    int s;
    do_load(16'h1234, 4'b0000);
    for (int i = 0; i < 3*FRAME; i++) begin
      step();
      if (obs !== want) begin miscompares++; $display("FAIL scan t=%0d obs=%h want=%h", m_t, obs, want); end
      vectors++;
      s = m_t - 1;
      if (s >= FRAME) begin
        if (s % R == 0) begin
          if (bus.enable !== 4'hF) begin miscompares++; $display("FAIL slot_blank t=%0d en=%h want=F", s, bus.enable); end
        end else if ({bus.enable, bus.segments} !== {ee[(s/R)%N], es[(s/R)%N]}) begin
          miscompares++;
          $display("FAIL slot_order t=%0d en=%h seg=%h want en=%h seg=%h", s, bus.enable, bus.segments, ee[(s/R)%N], es[(s/R)%N]);
        end
        vectors++;
        if (bus.frame_sync !== (s % FRAME == 0)) begin
          miscompares++; $display("FAIL frame_sync t=%0d got=%b want=%b", s, bus.frame_sync, s % FRAME == 0);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_decode();
    for (int v = 0; v < 16; v++) begin
      do_load({$urandom_range(0, 16'hFFF), 4'(v)}, 4'($urandom));
      for (int i = 0; i < 2*FRAME; i++) begin
        step();
        if (obs !== want) begin miscompares++; $display("FAIL decode v=%0d t=%0d obs=%h want=%h", v, m_t, obs, want); end
        vectors++;
      end
    end
  endtask

  task automatic test_double_buffer();
    repeat ($urandom_range(1, FRAME-3)) step();
    if (m_t % FRAME == FRAME-1) step();
    do_load(16'hAAAA, 4'b0000);
    do_load(16'hAAAA, 4'b0000);
    for (int i = 0; i < 2*FRAME; i++) begin
      step();
      if (obs !== want) begin miscompares++; $display("FAIL dbuf t=%0d obs=%h want=%h", m_t, obs, want); end
      vectors++;
    end
    while (m_t % FRAME != FRAME-1) step();
    do_load(16'h5E7B, 4'b0100);
    for (int i = 0; i < FRAME+2; i++) begin
      step();
      if (obs !== want) begin miscompares++; $display("FAIL bnd_load t=%0d obs=%h want=%h", m_t, obs, want); end
      vectors++;
    end
  endtask

  task automatic test_mask_dp();
    bus.digit_mask = 4'b0100;
    do_load(16'h8F06, 4'b0001);
    for (int i = 0; i < 3*FRAME; i++) begin
      step();
      if (obs !== want) begin miscompares++; $display("FAIL mask_dp t=%0d obs=%h want=%h", m_t, obs, want); end
      vectors++;
    end
    bus.digit_mask = 4'b0000;
  endtask

`ifdef SEVEN_SEG_SCAN_LZB_EN
  task automatic test_lzb();
    logic [15:0] vals [4] = '{16'h0050, 16'h0000, 16'h0007, 16'h0300};
    for (int n = 0; n < 4; n++) begin
      do_load(vals[n], (n == 3) ? 4'b0100 : 4'b0000);
      for (int i = 0; i < 2*FRAME+4; i++) begin
        step();
        if (obs !== want) begin miscompares++; $display("FAIL lzb v=%h t=%0d obs=%h want=%h", vals[n], m_t, obs, want); end
        vectors++;
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) bus.digit_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        bus.value = 16'($urandom);
        if ($urandom_range(0, 3) == 0) bus.value[15:8] = 8'h00;
        bus.dp = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
        bus.load = 1'b1;
      end
      step();
      bus.load = 1'b0;
      if (obs !== want) begin miscompares++; $display("FAIL random t=%0d obs=%h want=%h", m_t, obs, want); end
      vectors++;
    end
    bus.digit_mask = 4'b0000;
  endtask

  initial begin
    bus.value = '0; bus.dp = '0; bus.load = 1'b0; bus.digit_mask = '0;
    model_reset();
    test_reset();
    test_first_slot_and_scan();
    test_decode();
    test_double_buffer();
    test_mask_dp();
`ifdef SEVEN_SEG_SCAN_LZB_EN
    test_lzb();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
